pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Control side of the PC register: drives nextPC/nextPCop/intVec into the PC and reads the current PC back.
//  Sequences instruction fetch through an imem req/ack handshake and holds each fetched word until decode accepts it.
//  Applies branch redirects and, optionally, interrupt vectoring.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC after reset (the PC_OP_RESET target; informational, checked by TB)
//  TRAP_VEC  32'h0000_0100  interrupt handler address (word aligned)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   synchronous reset, active low
//  pc_i           in   32  current PC from the PC register
//  nextPC         out  32  PC load value (used when nextPCop = ASSIGN)
//  nextPCop       out  2   00 NOP, 01 INC(+4), 10 ASSIGN, 11 RESET
//  intVec         out  1   one-cycle pulse when the PC is loaded with TRAP_VEC
//  imem_req       out  1   fetch request; imem_addr held stable while high
//  imem_addr      out  32  fetch address (= pc_i)
//  imem_ack       in   1   fetch data valid, single cycle
//  imem_rdata     in   32  fetched instruction
//  instr_valid    out  1   held instruction available to decode
//  instr_ready    in   1   decode accepts the instruction
//  instr          out  32  held instruction
//  instr_pc       out  32  PC of the held instruction
//  branch_valid   in   1   redirect pulse from execute
//  branch_target  in   32  redirect address; bits [1:0] forced to 0 on capture
//  irq            in   1   level interrupt request (PCSEQ_IRQ_EN only)
//  irq_ack        out  1   one-cycle pulse, same cycle as intVec
//  epc            out  32  PC of the interrupted (discarded) instruction
// BEHAVIOUR
//  - States: S_RESET, S_FETCH, S_ISSUE, S_REDIRECT, S_TRAP. Outputs are Moore, decoded from state and registers.
//  - rst_n low at a clock edge: state <= S_RESET; instr/instr_pc/epc/redirect_q cleared.
//    nextPCop = 11 while rst_n is low and during S_RESET. All other outputs 0. Reset mid-fetch aborts without waiting for imem_ack.
//  - S_RESET: lasts one cycle after rst_n rises, then S_FETCH.
//  - S_FETCH: imem_req=1, imem_addr=pc_i, nextPCop=NOP. Exit on imem_ack:
//    - redirect_q pending: data dropped -> S_REDIRECT.
//    - else irq high (IRQ_EN): data dropped, epc <= pc_i -> S_TRAP.
//    - else instr <= imem_rdata, instr_pc <= pc_i -> S_ISSUE.
//  - S_ISSUE: instr_valid=1 unless branch_valid is high this cycle (combinationally gated).
//    - branch_valid high: instruction dropped -> S_REDIRECT.
//    - else on instr_ready: nextPCop=INC -> S_FETCH. PC is +4 after that edge.
//    - else hold; instr and instr_pc stay stable.
//  - branch_valid in any non-reset state: redirect_q <= {branch_target[31:2], 2'b00}, pending=1; the last pulse wins.
//    A branch that arrives in S_FETCH waits for imem_ack; the bus transaction is never abandoned.
//  - S_REDIRECT: nextPCop=ASSIGN, nextPC=redirect_q; clear pending -> S_FETCH. Redirect-to-new-fetch is 2 cycles.
//  - S_TRAP: nextPCop=ASSIGN, nextPC=TRAP_VEC, intVec=1, irq_ack=1 for one cycle -> S_FETCH.
//  - Priority at the fetch boundary: reset > redirect > irq > normal issue.
//  - PC arithmetic is done only by the PC register (mod 2^32 wrap); this block never adds.
// CONFIGURATION
//  PCSEQ_IRQ_EN defined: irq is sampled as above, S_TRAP exists, epc/irq_ack/intVec are live.
//  Not defined: irq is ignored, S_TRAP is not built, and intVec, irq_ack and epc are tied to 0.
// STRUCTURE
//  pc_pkg: PC_OP_NOP/INC/ASSIGN/RESET constants and the state encoding; shared with the PC register.
//  No sub-module. FSM, holding register and redirect latch stay in this one module.
// TESTING
//  1 rst_n=0 for 3 cycles then 1 -> nextPCop=11 for 4 cycles, then imem_req=1, imem_addr=0x0.
//  2 ack at 0x0 with rdata 0x00000013, instr_ready=1 -> instr_valid for 1 cycle, INC, next imem_addr=0x4.
//  3 instr_ready=0 for 5 cycles -> instr and instr_pc stable, nextPCop=NOP, no new imem_req.
//  4 branch_valid with target 0x203 during S_ISSUE -> instr_valid low that cycle, ASSIGN nextPC=0x200, then fetch 0x200.
//  5 branch_valid to 0x80 during outstanding fetch at 0x10, ack 3 cycles later -> data dropped, PC=0x80.
//  6 (IRQ_EN) irq=1, ack at 0x24 -> epc=0x24, intVec and irq_ack 1-cycle pulse, nextPC=TRAP_VEC, next fetch 0x100.
//    Macro off: same stimulus -> normal issue, intVec stays 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared PC-control definitions: PC register opcodes, default addresses and sequencer states.
package pc_pkg;

  localparam logic [1:0] PC_OP_NOP    = 2'b00;
  localparam logic [1:0] PC_OP_INC    = 2'b01;
  localparam logic [1:0] PC_OP_ASSIGN = 2'b10;
  localparam logic [1:0] PC_OP_RESET  = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_REDIRECT = 3'd3,
    S_TRAP     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// PC control sequencer: fetch handshake, instruction holding register, branch redirect latch.
// Optional interrupt vectoring is built when PCSEQ_IRQ_EN is defined.
//
// state      | meaning
// S_RESET    | one cycle after reset release, PC held at reset value
// S_FETCH    | imem request outstanding at pc_i, waiting for imem_ack
// S_ISSUE    | fetched word held for decode until instr_ready
// S_REDIRECT | load PC with the latched branch target
// S_TRAP     | load PC with TRAP_VEC, pulse intVec/irq_ack
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic [31:0] nextPC,
  output logic [1:0]  nextPCop,
  output logic        intVec,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] epc
);

  seq_state_t  state_q, state_d;
  logic [31:0] instr_q, instr_pc_q, redirect_q, epc_q;
  logic        pending_q;
  logic        redirect_now;
  logic        unused_cfg;

  // A branch landing in the same cycle as the ack must also drop the fetched word.
  assign redirect_now = pending_q | branch_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          if (redirect_now) state_d = S_REDIRECT;
`ifdef PCSEQ_IRQ_EN
          else if (irq) state_d = S_TRAP;
`endif
          else state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (branch_valid) state_d = S_REDIRECT;
        else if (instr_ready) state_d = S_FETCH;
      end
      S_REDIRECT: state_d = S_FETCH;
      S_TRAP:     state_d = S_FETCH;
      default:    state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      instr_q    <= '0;
      instr_pc_q <= '0;
      redirect_q <= '0;
      pending_q  <= 1'b0;
      epc_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && state_d == S_ISSUE) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc_i;
      end
      if (state_q == S_FETCH && state_d == S_TRAP) epc_q <= pc_i;
      // A new pulse overrides both an older target and the clear in S_REDIRECT.
      if (state_q != S_RESET && branch_valid) begin
        redirect_q <= {branch_target[31:2], 2'b00};
        pending_q  <= 1'b1;
      end else if (state_q == S_REDIRECT) begin
        pending_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    nextPC      = '0;
    nextPCop    = PC_OP_NOP;
    intVec      = 1'b0;
    irq_ack     = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
`ifdef PCSEQ_IRQ_EN
    epc         = epc_q;
`else
    epc         = '0;
`endif
    case (state_q)
      S_RESET: nextPCop = PC_OP_RESET;
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_i;
      end
      S_ISSUE: begin
        instr_valid = ~branch_valid;
        if (!branch_valid && instr_ready) nextPCop = PC_OP_INC;
      end
      S_REDIRECT: begin
        nextPCop = PC_OP_ASSIGN;
        nextPC   = redirect_q;
      end
`ifdef PCSEQ_IRQ_EN
      S_TRAP: begin
        nextPCop = PC_OP_ASSIGN;
        nextPC   = TRAP_VEC;
        intVec   = 1'b1;
        irq_ack  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!rst_n) begin
      nextPC      = '0;
      nextPCop    = PC_OP_RESET;
      intVec      = 1'b0;
      irq_ack     = 1'b0;
      imem_req    = 1'b0;
      imem_addr   = '0;
      instr_valid = 1'b0;
      instr       = '0;
      instr_pc    = '0;
      epc         = '0;
    end
  end

`ifdef PCSEQ_IRQ_EN
  assign unused_cfg = ^RESET_PC;
`else
  assign unused_cfg = ^{RESET_PC, TRAP_VEC, irq, epc_q};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register in the loop.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic [31:0] nextPC;
  logic [1:0]  nextPCop;
  logic        intVec;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        irq;
  logic        irq_ack;
  logic [31:0] epc;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .nextPC(nextPC), .nextPCop(nextPCop),
    .intVec(intVec), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .branch_valid(branch_valid),
    .branch_target(branch_target), .irq(irq), .irq_ack(irq_ack), .epc(epc)
  );

  always #5 clk = ~clk;

  // PC register model: the only place PC arithmetic happens.
  initial pc_i = 32'hDEAD_BEEF;
  always @(posedge clk) begin
    case (nextPCop)
      PC_OP_INC:    pc_i <= pc_i + 32'd4;
      PC_OP_ASSIGN: pc_i <= nextPC;
      PC_OP_RESET:  pc_i <= RESET_PC_DEF;
      default:      pc_i <= pc_i;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = '0; irq = 1'b0;

    // reset held 3 cycles, then one S_RESET cycle
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_op", 32'(nextPCop), 32'(PC_OP_RESET));
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      tick();
    end
    rst_n = 1'b1;
    settle();
    chk("sreset_op", 32'(nextPCop), 32'(PC_OP_RESET));
    chk("sreset_req", 32'(imem_req), 0);
    tick();
    settle();
    chk("fetch0_req", 32'(imem_req), 1);
    chk("fetch0_addr", imem_addr, 32'h0);
    chk("fetch0_op", 32'(nextPCop), 32'(PC_OP_NOP));
    chk("reset_pc", pc_i, 32'h0);

    // fetch at 0x0, decode accepts immediately
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    settle();
    chk("fetch_nvalid", 32'(instr_valid), 0);
    tick();
    imem_ack = 1'b0; instr_ready = 1'b1;
    settle();
    chk("issue_valid", 32'(instr_valid), 1);
    chk("issue_instr", instr, 32'h0000_0013);
    chk("issue_pc", instr_pc, 32'h0);
    chk("issue_inc", 32'(nextPCop), 32'(PC_OP_INC));
    tick();
    instr_ready = 1'b0;
    settle();
    chk("valid_1cyc", 32'(instr_valid), 0);
    chk("fetch4_addr", imem_addr, 32'h4);
    chk("fetch4_req", 32'(imem_req), 1);

    // decode stalls for 5 cycles
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", instr, 32'hAAAA_5555);
      chk("stall_pc", instr_pc, 32'h4);
      chk("stall_op", 32'(nextPCop), 32'(PC_OP_NOP));
      chk("stall_req", 32'(imem_req), 0);
      tick();
    end

    // branch during issue, target low bits forced to 0
    branch_valid = 1'b1; branch_target = 32'h0000_0203; instr_ready = 1'b1;
    settle();
    chk("br_gate_valid", 32'(instr_valid), 0);
    chk("br_no_inc", 32'(nextPCop), 32'(PC_OP_NOP));
    tick();
    branch_valid = 1'b0; instr_ready = 1'b0;
    settle();
    chk("redir_op", 32'(nextPCop), 32'(PC_OP_ASSIGN));
    chk("redir_pc", nextPC, 32'h200);
    tick();
    settle();
    chk("fetch200_addr", imem_addr, 32'h200);
    chk("fetch200_req", 32'(imem_req), 1);

    // get to 0x10: issue at 0x200, branch to 0x10
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0; branch_valid = 1'b1; branch_target = 32'h10;
    tick();
    branch_valid = 1'b0;
    tick();
    settle();
    chk("fetch10_addr", imem_addr, 32'h10);

    // branch during outstanding fetch, ack 3 cycles later
    branch_valid = 1'b1; branch_target = 32'h80;
    tick();
    branch_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("wait_req", 32'(imem_req), 1);
      chk("wait_addr", imem_addr, 32'h10);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    settle();
    chk("drop_op", 32'(nextPCop), 32'(PC_OP_ASSIGN));
    chk("drop_pc", nextPC, 32'h80);
    chk("drop_valid", 32'(instr_valid), 0);
    chk("drop_instr", instr, 32'h1111_1111);
    tick();
    settle();
    chk("fetch80_addr", imem_addr, 32'h80);

    // get to 0x24: issue at 0x80, branch to 0x24
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ack = 1'b0; branch_valid = 1'b1; branch_target = 32'h24;
    tick();
    branch_valid = 1'b0;
    tick();
    settle();
    chk("fetch24_addr", imem_addr, 32'h24);

    // interrupt at fetch boundary
    irq = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    irq = 1'b0; imem_ack = 1'b0;
    settle();
`ifdef PCSEQ_IRQ_EN
    chk("trap_intvec", 32'(intVec), 1);
    chk("trap_irqack", 32'(irq_ack), 1);
    chk("trap_epc", epc, 32'h24);
    chk("trap_op", 32'(nextPCop), 32'(PC_OP_ASSIGN));
    chk("trap_pc", nextPC, 32'h100);
    chk("trap_valid", 32'(instr_valid), 0);
    tick();
    settle();
    chk("trap_intvec_1cyc", 32'(intVec), 0);
    chk("trap_irqack_1cyc", 32'(irq_ack), 0);
    chk("fetch100_addr", imem_addr, 32'h100);
`else
    chk("noirq_valid", 32'(instr_valid), 1);
    chk("noirq_instr", instr, 32'h3333_3333);
    chk("noirq_pc", instr_pc, 32'h24);
    chk("noirq_intvec", 32'(intVec), 0);
    chk("noirq_irqack", 32'(irq_ack), 0);
    chk("noirq_epc", epc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    settle();
    chk("fetch28_addr", imem_addr, 32'h28);
`endif

    // reset in the middle of a fetch, no ack ever arrives
    chk("mid_req", 32'(imem_req), 1);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_op", 32'(nextPCop), 32'(PC_OP_RESET));
    chk("mid_rst_req", 32'(imem_req), 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("mid_sreset_op", 32'(nextPCop), 32'(PC_OP_RESET));
    chk("mid_instr_clr", instr, 32'h0);
    chk("mid_epc_clr", epc, 32'h0);
    tick();
    settle();
    chk("mid_fetch_addr", imem_addr, 32'h0);
    chk("mid_fetch_req", 32'(imem_req), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
